// File: rtl/axi_wr_arbiter.sv
// Round-robin sequencer that shares one AXI4 write port (AW/W/B) between NUM_REQ writer engines.
// Each granted writer gets one full burst: address, data beats with WLAST, then the B response.
module axi_wr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*LEN_W-1:0]    req_len,
   output logic [NUM_REQ-1:0]          grant,
   input  logic [NUM_REQ*DATA_W-1:0]   s_wdata,
   input  logic [NUM_REQ-1:0]          s_wvalid,
   output logic [NUM_REQ-1:0]          s_wready,
   output logic [NUM_REQ-1:0]          done,
   output logic [NUM_REQ-1:0]          err,
   output logic [ADDR_W-1:0]           awaddr,
   output logic [LEN_W-1:0]            awlen,
   output logic                        awvalid,
   input  logic                        awready,
   output logic [DATA_W-1:0]           wdata,
   output logic                        wlast,
   output logic                        wvalid,
   input  logic                        wready,
   input  logic [1:0]                  bresp,
   input  logic                        bvalid,
   output logic                        bready
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t               state_reg;
   logic [IDX_W-1:0]     rr_ptr_reg;
   logic [IDX_W-1:0]     owner_reg;
   logic [NUM_REQ-1:0]   grant_reg;
   logic [NUM_REQ-1:0]   done_reg;
   logic [NUM_REQ-1:0]   err_reg;
   logic [ADDR_W-1:0]    awaddr_reg;
   logic [LEN_W-1:0]     awlen_reg;
   logic                 awvalid_reg;
   logic                 bready_reg;
   logic [LEN_W:0]       beat_cnt_reg;

   logic                 win_found;
   logic [IDX_W-1:0]     win_idx;
   logic [IDX_W:0]       arb_cand;
   logic                 in_data;
   logic                 beat_fire;

   // Search upward from the rr pointer with wrap; the first requester found wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      arb_cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         arb_cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
         if (arb_cand >= NUM_REQ_W) begin
            arb_cand = arb_cand - NUM_REQ_W;
         end
         if (!win_found && req[arb_cand[IDX_W-1:0]]) begin
            win_found = 1'b1;
            win_idx   = arb_cand[IDX_W-1:0];
         end
      end
   end

   assign in_data   = (state_reg == DATA);
   assign wdata     = s_wdata[owner_reg*DATA_W +: DATA_W];
   assign wvalid    = in_data & s_wvalid[owner_reg];
   assign wlast     = in_data & (beat_cnt_reg == {1'b0, awlen_reg});
   assign beat_fire = wvalid & wready;

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sready
         assign s_wready[gi] = in_data & grant_reg[gi] & wready;
      end
   endgenerate

   assign grant   = grant_reg;
   assign done    = done_reg;
   assign err     = err_reg;
   assign awaddr  = awaddr_reg;
   assign awlen   = awlen_reg;
   assign awvalid = awvalid_reg;
   assign bready  = bready_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         rr_ptr_reg   <= '0;
         owner_reg    <= '0;
         grant_reg    <= '0;
         done_reg     <= '0;
         err_reg      <= '0;
         awaddr_reg   <= '0;
         awlen_reg    <= '0;
         awvalid_reg  <= 1'b0;
         bready_reg   <= 1'b0;
         beat_cnt_reg <= '0;
      end else begin
         done_reg <= '0;
         err_reg  <= '0;
         case (state_reg)
            IDLE: begin
               if (win_found) begin
                  owner_reg   <= win_idx;
                  grant_reg   <= NUM_REQ'(1) << win_idx;
                  awaddr_reg  <= req_addr[win_idx*ADDR_W +: ADDR_W];
                  awlen_reg   <= req_len[win_idx*LEN_W +: LEN_W];
                  awvalid_reg <= 1'b1;
                  state_reg   <= ADDR;
               end
            end
            ADDR: begin
               if (awready) begin
                  awvalid_reg  <= 1'b0;
                  beat_cnt_reg <= '0;
                  state_reg    <= DATA;
               end
            end
            DATA: begin
               if (beat_fire) begin
                  beat_cnt_reg <= beat_cnt_reg + 1'b1;
                  if (wlast) begin
                     bready_reg <= 1'b1;
                     state_reg  <= RESP;
                  end
               end
            end
            RESP: begin
               if (bvalid) begin
                  bready_reg <= 1'b0;
                  done_reg   <= grant_reg;
                  err_reg    <= (bresp != 2'b00) ? grant_reg : '0;
                  grant_reg  <= '0;
                  // The finishing owner drops to lowest priority for the next round.
                  rr_ptr_reg <= (owner_reg == LAST_IDX) ? '0 : owner_reg + IDX_W'(1);
                  state_reg  <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed and randomized bench for axi_wr_arbiter; expected grants, addresses, beat data and
// responses come from a round-robin model and per-requester data patterns held in the bench.
module tb_axi_wr_arbiter;
   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req;
   logic [N*AW-1:0]   req_addr;
   logic [N*LW-1:0]   req_len;
   logic [N-1:0]      grant;
   logic [N*DW-1:0]   s_wdata;
   logic [N-1:0]      s_wvalid;
   logic [N-1:0]      s_wready;
   logic [N-1:0]      done;
   logic [N-1:0]      err;
   logic [AW-1:0]     awaddr;
   logic [LW-1:0]     awlen;
   logic              awvalid;
   logic              awready;
   logic [DW-1:0]     wdata;
   logic              wlast;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;

   int n_cmp = 0;
   int n_bad = 0;
   int m_ptr = 0;
   int burst_no[N];
   int sent[N];

   axi_wr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len), .grant(grant),
      .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready), .done(done), .err(err),
      .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready), .wdata(wdata),
      .wlast(wlast), .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid),
      .bready(bready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] pat(input int i, input int b, input int k);
      return DW'((i << 28) | ((b & 'hFFF) << 16) | (k & 'hFFFF));
   endfunction

   task automatic drive_data();
      for (int i = 0; i < N; i++) s_wdata[i*DW +: DW] = pat(i, burst_no[i], sent[i]);
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input int l);
      req[i] = 1'b1;
      req_addr[i*AW +: AW] = a;
      req_len[i*LW +: LW] = LW'(l);
   endtask

   function automatic int pick();
      for (int k = 0; k < N; k++) if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return 0;
   endfunction

   task automatic chk_idle(input string t);
      chk({t, "_grant"}, grant, 0);
      chk({t, "_awvalid"}, awvalid, 0);
      chk({t, "_awaddr"}, awaddr, 0);
      chk({t, "_awlen"}, awlen, 0);
      chk({t, "_bready"}, bready, 0);
      chk({t, "_done"}, done, 0);
      chk({t, "_err"}, err, 0);
      chk({t, "_wvalid"}, wvalid, 0);
      chk({t, "_wlast"}, wlast, 0);
      chk({t, "_s_wready"}, s_wready, 0);
   endtask

   // One complete burst: wr_mode 0 = wready always, 1 = toggling, 2 = random.
   task automatic run_burst(input int aw_dly, input int wr_mode, input int b_dly,
                            input logic [1:0] resp, input bit rnd, input int exp_w,
                            output int w, output int ncyc);
      logic [N-1:0] oh;
      logic [AW-1:0] ea;
      int len, beats, guard;
      w = (exp_w >= 0) ? exp_w : pick();
      oh = '0;
      oh[w] = 1'b1;
      ea = req_addr[w*AW +: AW];
      len = int'(req_len[w*LW +: LW]);
      ncyc = 0;
      s_wvalid = '1;
      drive_data();
      cyc(); ncyc++;
      chk("grant", grant, oh);
      chk("done_clear", done, 0);
      for (int d = 0; d <= aw_dly; d++) begin
         awready = (d == aw_dly);
         #1;
         chk("aw_valid", awvalid, 1);
         chk("aw_addr", awaddr, ea);
         chk("aw_len", awlen, len);
         chk("no_w_before_aw", wvalid, 0);
         chk("no_sready_before_aw", s_wready, 0);
         cyc(); ncyc++;
      end
      awready = 1'b0;
      beats = 0;
      guard = 0;
      while (beats <= len && guard < 300) begin
         wready = (wr_mode == 0) ? 1'b1 : (wr_mode == 1) ? (guard % 2 == 0)
                                         : ($urandom_range(0, 9) < 7);
         if (rnd) begin
            for (int i = 0; i < N; i++) begin
               s_wvalid[i] = (i == w) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
               if (i != w && !req[i] && $urandom_range(0, 7) == 0)
                  set_req(i, $urandom & 32'hFFFF_FFC0, $urandom_range(0, 15));
            end
         end else begin
            s_wvalid = '1;
         end
         drive_data();
         #1;
         chk("wvalid", wvalid, s_wvalid[w]);
         chk("s_wready", s_wready, wready ? oh : '0);
         chk("wlast", wlast, beats == len);
         if (s_wvalid[w]) chk("wdata", wdata, pat(w, burst_no[w], beats));
         if (s_wvalid[w] && wready) beats++;
         for (int i = 0; i < N; i++) if (s_wvalid[i] && s_wready[i]) sent[i]++;
         cyc(); ncyc++; guard++;
      end
      if (guard >= 300) chk("data_timeout", beats, len + 1);
      wready = 1'b0;
      s_wvalid = '1;
      for (int d = 0; d <= b_dly; d++) begin
         bvalid = (d == b_dly);
         bresp = (d == b_dly) ? resp : 2'($urandom_range(0, 3));
         #1;
         chk("bready", bready, 1);
         chk("no_extra_beat", wvalid, 0);
         chk("done_early", done, 0);
         cyc(); ncyc++;
      end
      bvalid = 1'b0;
      chk("done", done, oh);
      chk("err", err, (resp != 2'b00) ? oh : '0);
      chk("grant_released", grant, 0);
      chk("bready_low", bready, 0);
      chk("awvalid_low", awvalid, 0);
      $display("burst owner=%0d addr=0x%08h len=%0d beats=%0d resp=%0d cycles=%0d",
               w, ea, len, beats, resp, ncyc);
      m_ptr = (w + 1) % N;
      burst_no[w]++;
      sent[w] = 0;
      req[w] = 1'b0;
   endtask

   initial begin
      int w, nc;
      int order[6];
      order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0; order[5] = 1;
      for (int i = 0; i < N; i++) begin burst_no[i] = 0; sent[i] = 0; end
      rst = 1'b1;
      req = '0; req_addr = '0; req_len = '0; s_wdata = '0;
      s_wvalid = '1; awready = 1'b1; wready = 1'b1; bresp = 2'b00; bvalid = 1'b1;
      cyc(); cyc();
      chk_idle("reset");
      rst = 1'b0;
      s_wvalid = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
      m_ptr = 0;

      // Single-beat burst, all handshakes immediate
      set_req(0, 32'h0000_1000, 0);
      run_burst(0, 0, 0, 2'b00, 1'b0, 0, w, nc);
      chk("t1_req_to_done", nc, 4);

      // 8-beat row with toggling wready
      set_req(2, 32'h0000_2000, 7);
      run_burst(0, 1, 0, 2'b00, 1'b0, 2, w, nc);

      // AW stalled three cycles
      set_req(1, 32'h0000_3000, 3);
      run_burst(3, 0, 0, 2'b00, 1'b0, 1, w, nc);

      // SLVERR response
      set_req(0, 32'h0000_4000, 1);
      run_burst(0, 0, 1, 2'b10, 1'b0, 0, w, nc);

      // Reset during the fourth beat of an 8-beat burst
      set_req(2, 32'h0000_5000, 7);
      s_wvalid = '1;
      drive_data();
      cyc();
      chk("t6_grant", grant, 4'b0100);
      awready = 1'b1;
      #1;
      cyc();
      awready = 1'b0;
      wready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         drive_data();
         #1;
         for (int i = 0; i < N; i++) if (s_wvalid[i] && s_wready[i]) sent[i]++;
         cyc();
      end
      drive_data();
      #1;
      chk("t6_beat4_wdata", wdata, pat(2, burst_no[2], 3));
      rst = 1'b1;
      #1;
      chk_idle("t6_async");
      cyc();
      chk_idle("t6_edge");
      req = '0;
      wready = 1'b0;
      s_wvalid = '0;
      rst = 1'b0;
      sent[2] = 0;
      burst_no[2]++;
      m_ptr = 0;
      $display("reset mid-burst owner=2 beat=4");
      cyc();
      chk("t6_idle_grant", grant, 0);
      chk("t6_idle_awvalid", awvalid, 0);

      // Round-robin order with all writers re-requesting
      for (int i = 0; i < N; i++) set_req(i, 32'h0001_0000 + 32'(i * 'h100), i);
      for (int k = 0; k < 6; k++) begin
         run_burst(0, 0, 0, 2'b00, 1'b0, order[k], w, nc);
         if (k < 5) set_req(w, 32'h0002_0000 + 32'(k * 'h40), 1);
      end
      req[0] = 1'b0;
      req[2] = 1'b0;
      set_req(1, 32'h0003_0000, 2);
      run_burst(0, 0, 0, 2'b00, 1'b0, 3, w, nc);

      // Randomized bursts against the round-robin model
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < N; i++)
               if (!req[i] && $urandom_range(0, 1) == 1)
                  set_req(i, $urandom & 32'hFFFF_FFC0, $urandom_range(0, 15));
         end
         if (req == '0) begin
            cyc();
            chk("idle_awvalid", awvalid, 0);
            chk("idle_grant", grant, 0);
            set_req($urandom_range(0, N - 1), $urandom & 32'hFFFF_FFC0, $urandom_range(0, 15));
         end
         run_burst($urandom_range(0, 3), 2, $urandom_range(0, 2), 2'($urandom_range(0, 3)),
                   1'b1, -1, w, nc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
